mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store) of the five-stage MIPS pipeline. Grants one access at a time, sequences the fixed-latency memory, returns read data with a one-cycle ready pulse, and drives stall signals consumed by the pipeline's stall/hazard logic alongside the load-use stall. MEM-stage accesses have priority over fetch, because they belong to the older instruction.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read/write latency in cycles after mem_en; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- if_req  in  1  fetch request, level; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, level; held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid while dm_ready=1
- dm_ready  out  1  one-cycle completion pulse for data
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  dm_req & ~dm_ready (combinational)
- mem_en  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered access address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, valid exactly MEM_LAT cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if dm_req=1, grant DM; else if if_req=1, grant IF; else stay. On grant, latch owner, address, we and wdata, then go to ISSUE.
- ISSUE: mem_en=1 for exactly one cycle. Load the counter with MEM_LAT−1, then go to WAIT.
- WAIT: decrement the counter. At 0, capture mem_rdata into the owner's rdata register (loads only), then go to RESP.
- RESP: the owner's ready=1 for one cycle, then go to IDLE. The next arbitration happens in IDLE.
- Stores: dm_ready pulses the same way. dm_rdata holds its previous value.
- if_rdata and dm_rdata are separate registers. Each holds its value until overwritten by its own next read.
- A requester that deasserts req mid-access is a protocol violation. The access still completes and ready still pulses.
- Simultaneous if_req and dm_req in IDLE: DM is served first. IF is granted on the next IDLE visit.
- No fairness counter. The pipeline stalls on stall_mem, so DM cannot starve IF indefinitely.

## Timing
- Reset values: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, counter=0.
- Latency: req sampled in IDLE at cycle T → mem_en at T+1 → mem_rdata valid at T+1+MEM_LAT → ready at T+2+MEM_LAT.
- Back-to-back accesses from one requester start every MEM_LAT+3 cycles.
- stall_* deasserts in the ready cycle so the stage advances on that edge.
- Reset asserted mid-access aborts it: no ready pulse, and mem_en drops immediately (async).

## Configuration
- MEM_PORT_ARBITER_PERF_EN defined:
  - Adds outputs perf_if_stall (32) and perf_dm_stall (32).
  - Each counts cycles in which its stall signal is 1.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Not defined: the ports and counters are absent, and the behaviour is otherwise identical.

## Structure
- Shared package mips_mem_pkg holds:
  - the arb_state_t enum (IDLE, ISSUE, WAIT, RESP);
  - the owner encoding (OWN_IF=0, OWN_DM=1);
  - the default MEM_LAT constant.
- One sub-module, memarb_sat_cnt: a 32-bit saturating event counter, instantiated twice only under MEM_PORT_ARBITER_PERF_EN.

## Test plan
- Reset, then idle: all outputs 0; no mem_en for 20 cycles.
- MEM_LAT=2, single fetch: if_req=1 with if_addr=0x0040_0000, memory returns 0x2008_0005. Required: mem_en at T+1, if_ready at T+4 with if_rdata=0x2008_0005, stall_if=1 for cycles T..T+3.
- Simultaneous if_req and dm_req (load from 0x1001_0000 → 0xDEAD_BEEF):
  - dm_ready pulses first with dm_rdata=0xDEAD_BEEF;
  - the IF access is issued at the next IDLE, and if_ready follows MEM_LAT+3 cycles after dm_ready.
- Store: dm_we=1, dm_addr=0x1001_0004, dm_wdata=0x1234_5678 → mem_en=1 and mem_we=1 for one cycle with those values, dm_ready pulses, dm_rdata unchanged.
- rst_n pulled low during WAIT → state IDLE, outputs at reset values, no ready pulse. After release, the held request restarts from ISSUE.
- With MEM_PORT_ARBITER_PERF_EN: one fetch at MEM_LAT=2 → perf_if_stall=4. Forcing a count near 0xFFFFFFFF → it saturates and does not wrap.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mips_mem_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Access owner encoding
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Default memory latency in cycles after mem_en
    localparam int unsigned MEM_LAT_DEFAULT = 2;

    // Latency counter width, enough for MEM_LAT up to 15
    localparam int unsigned LAT_CNT_W = 4;

    // Performance counter width
    localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/memarb_sat_cnt.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
module memarb_sat_cnt
    import mips_mem_pkg::*;
#(
    parameter int unsigned W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment on event unless already saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and load/store (MEM).
// MEM-stage requests win over fetch. Optional stall-cycle counters are enabled by
// defining MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_if_stall,
    output logic [PERF_CNT_W-1:0] perf_dm_stall
`endif
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic [LAT_CNT_W-1:0] cnt_d;
    logic                 owner_q;
    logic                 we_q;
    logic                 grant;
    logic                 grant_own;
    logic                 wait_done;

    // State and latency counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, latency countdown in WAIT
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        grant_own = OWN_IF;
        wait_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dm_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_DM;
                    state_d   = S_ISSUE;
                end else if (if_req) begin
                    grant     = 1'b1;
                    grant_own = OWN_IF;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    wait_done = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant latch and one-cycle memory strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_IF;
            we_q      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= grant;
            mem_we <= grant && (grant_own == OWN_DM) && dm_we;
            if (grant) begin
                owner_q <= grant_own;
                if (grant_own == OWN_DM) begin
                    we_q      <= dm_we;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                end else begin
                    we_q     <= 1'b0;
                    mem_addr <= if_addr;
                end
            end
        end
    end

    // Read data capture and ready pulses, one per completed access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_ready <= wait_done && (owner_q == OWN_IF);
            dm_ready <= wait_done && (owner_q == OWN_DM);
            if (wait_done && (owner_q == OWN_IF)) begin
                if_rdata <= mem_rdata;
            end
            if (wait_done && (owner_q == OWN_DM) && !we_q) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

`ifdef MEM_PORT_ARBITER_PERF_EN
    // Stall-cycle counters
    memarb_sat_cnt #(.W(PERF_CNT_W)) u_perf_if (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_if),
        .count (perf_if_stall)
    );

    memarb_sat_cnt #(.W(PERF_CNT_W)) u_perf_dm (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_mem),
        .count (perf_dm_stall)
    );
`endif

endmodule
